// File: rtl/flag_sync_pkg.sv
// flag_sync_pkg: shared width helper, default stretch length and reset values for the flag crossing
package flag_sync_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int DEF_STRETCH = 8;
  localparam int REM_W = clog2(DEF_STRETCH + 1);
  localparam logic RST_BIT = 1'b0;
endpackage

// File: rtl/flag_sync_chan.sv
// flag_sync_chan: one flag channel - synchroniser, rising-edge pulse, stretcher, saturating counter
// Ports: clock, reset (sync, active-high), flagAsync (foreign-domain level), countClear (clears counter),
//        levelOut (synchronised level), pulseOut (one-cycle rise pulse), stretchOut (stretched pulse),
//        eventCount (saturating event count)
module flag_sync_chan
  import flag_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int STRETCH = DEF_STRETCH,
  parameter int RETRIGGER = 1,
  parameter int CNT_W = 8,
  parameter int REM_WIDTH = REM_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flagAsync,
  input  logic             countClear,
  output logic             levelOut,
  output logic             pulseOut,
  output logic             stretchOut,
  output logic [CNT_W-1:0] eventCount
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic [REM_WIDTH-1:0] rem;
  logic ev;
  logic accept;
  assign levelOut = sync[SYNC_STAGES-1];
  // ev is the value pulseOut takes at the next edge; the stretcher and counter act on it in the same edge
  always_comb begin
    ev = levelOut & ~prev;
    accept = ev & ((RETRIGGER != 0) || (rem == '0));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      prev <= RST_BIT;
      pulseOut <= RST_BIT;
      stretchOut <= RST_BIT;
      rem <= '0;
      eventCount <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], flagAsync};
      prev <= levelOut;
      pulseOut <= ev;
      if (accept) begin
        rem <= REM_WIDTH'(STRETCH);
        stretchOut <= 1'b1;
      end else if (rem > REM_WIDTH'(1)) begin
        rem <= rem - 1'b1;
      end else if (rem == REM_WIDTH'(1)) begin
        rem <= '0;
        stretchOut <= 1'b0;
      end
      eventCount <= countClear ? CNT_W'(ev) : (ev && eventCount != '1) ? eventCount + 1'b1 : eventCount;
    end
  end
endmodule

// File: rtl/flag_sync_multi.sv
// flag_sync_multi: CHANNELS independent asynchronous flags brought into the clock domain
// Ports: clock, reset (sync, active-high), flag_async[i], count_clear[i], level_out[i], pulse_out[i],
//        stretch_out[i], event_count[i*CNT_W +: CNT_W] for channel i
module flag_sync_multi
  import flag_sync_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 3,
  parameter int STRETCH = DEF_STRETCH,
  parameter int RETRIGGER = 1,
  parameter int CNT_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       flag_async,
  input  logic [CHANNELS-1:0]       count_clear,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       stretch_out,
  output logic [CHANNELS*CNT_W-1:0] event_count
);
  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    flag_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STRETCH(STRETCH),
      .RETRIGGER(RETRIGGER),
      .CNT_W(CNT_W),
      .REM_WIDTH(clog2(STRETCH + 1))
    ) uChan (
      .clock(clock),
      .reset(reset),
      .flagAsync(flag_async[i]),
      .countClear(count_clear[i]),
      .levelOut(level_out[i]),
      .pulseOut(pulse_out[i]),
      .stretchOut(stretch_out[i]),
      .eventCount(event_count[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_flag_sync_multi.sv
// tb_flag_sync_multi: directed and random checks of two flag_sync_multi configurations against an event-history model
module tb_flag_sync_multi;
  localparam int C = 4;
  localparam int S = 3;
  localparam int ST = 8;
  localparam int N = 8192;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [C-1:0] flag = '0;
  logic [C-1:0] clr = '0;
  logic [C-1:0] lvA, puA, stA, lvB, puB, stB;
  logic [C*8-1:0] cA;
  logic [C*2-1:0] cB;
  int errors = 0;
  int checks = 0;

  flag_sync_multi #(.CHANNELS(C), .SYNC_STAGES(S), .STRETCH(ST), .RETRIGGER(1), .CNT_W(8)) dutA (
    .clock(clock), .reset(reset), .flag_async(flag), .count_clear(clr),
    .level_out(lvA), .pulse_out(puA), .stretch_out(stA), .event_count(cA));
  flag_sync_multi #(.CHANNELS(C), .SYNC_STAGES(S), .STRETCH(ST), .RETRIGGER(0), .CNT_W(2)) dutB (
    .clock(clock), .reset(reset), .flag_async(flag), .count_clear(clr),
    .level_out(lvB), .pulse_out(puB), .stretch_out(stB), .event_count(cB));

  always #5 clock = ~clock;

  // Reference model: per-edge histories of sampled inputs, derived levels, rise events and
  // events accepted by a non-retriggering stretcher; outputs follow from time windows over them.
  int n = 0;
  int lastRst = 0;
  bit inH [C][N];
  bit lvH [C][N];
  bit evH [C][N];
  bit accB [C][N];
  logic [C-1:0] eLev, ePul, eStrA, eStrB;
  int cntA [C];
  int cntB [C];

  always @(posedge clock) begin
    n++;
    if (n >= N) begin
      $display("FAIL model_bound n=%0d limit=%0d", n, N);
      $fatal(1);
    end
    for (int c = 0; c < C; c++) begin
      if (reset) begin
        inH[c][n] = 0; lvH[c][n] = 0; evH[c][n] = 0; accB[c][n] = 0;
        eLev[c] = 0; ePul[c] = 0; eStrA[c] = 0; eStrB[c] = 0;
        cntA[c] = 0; cntB[c] = 0;
      end else begin
        inH[c][n] = flag[c];
        lvH[c][n] = (n - S + 1 > lastRst) && inH[c][n-S+1];
        evH[c][n] = (n - 1 > lastRst) && lvH[c][n-1] && !((n - 2 > lastRst) && lvH[c][n-2]);
        accB[c][n] = evH[c][n];
        for (int k = n - 1; k >= n - ST && k > lastRst; k--) if (accB[c][k]) accB[c][n] = 0;
        eStrA[c] = 0;
        eStrB[c] = 0;
        for (int k = n; k > n - ST && k > lastRst; k--) begin
          if (evH[c][k]) eStrA[c] = 1;
          if (accB[c][k]) eStrB[c] = 1;
        end
        eLev[c] = lvH[c][n];
        ePul[c] = evH[c][n];
        cntA[c] = clr[c] ? int'(evH[c][n]) : evH[c][n] ? (cntA[c] + 1 > 255 ? 255 : cntA[c] + 1) : cntA[c];
        cntB[c] = clr[c] ? int'(evH[c][n]) : evH[c][n] ? (cntB[c] + 1 > 3 ? 3 : cntB[c] + 1) : cntB[c];
      end
    end
    if (reset) lastRst = n;
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    flag = '0;
    clr = '0;
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    flag = '0;
    clr = '0;
    repeat (3) tick;
    checks++;
    if ({lvA, puA, stA, lvB, puB, stB} !== '0) begin
      errors++;
      $display("FAIL reset_bits got=%h want=0", {lvA, puA, stA, lvB, puB, stB});
    end
    checks++;
    if ({cA, cB} !== '0) begin
      errors++;
      $display("FAIL reset_counts got=%h want=0", {cA, cB});
    end
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick;
      checks++;
      if ({lvA, puA, stA, lvB, puB, stB, cA, cB} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cycle=%0d got=%h want=0", t, {lvA, puA, stA, lvB, puB, stB, cA, cB});
      end
    end
  endtask

  task automatic test_single_rise;
    int e0, firstLv, pulses, pEdge, highs, sEdge;
    do_reset;
    firstLv = -1; pEdge = -1; sEdge = -1; pulses = 0; highs = 0;
    flag[0] = 1'b1;
    e0 = n + 1;
    for (int t = 0; t < 16; t++) begin
      tick;
      if (lvA[0] && firstLv < 0) firstLv = n;
      if (puA[0]) begin pulses++; pEdge = n; end
      if (stA[0]) begin highs++; if (sEdge < 0) sEdge = n; end
      checks++;
      if ((lvA[3:1] | puA[3:1] | stA[3:1]) !== 3'b000) begin
        errors++;
        $display("FAIL rise_other_channels got=%b want=000", lvA[3:1] | puA[3:1] | stA[3:1]);
      end
    end
    checks++;
    if (firstLv !== e0 + 2) begin errors++; $display("FAIL rise_level_edge got=%0d want=%0d", firstLv, e0 + 2); end
    checks++;
    if (pulses !== 1 || pEdge !== e0 + 3) begin
      errors++;
      $display("FAIL rise_pulse got=%0d@%0d want=1@%0d", pulses, pEdge, e0 + 3);
    end
    checks++;
    if (highs !== ST || sEdge !== e0 + 3) begin
      errors++;
      $display("FAIL rise_stretch got=%0d@%0d want=%0d@%0d", highs, sEdge, ST, e0 + 3);
    end
    checks++;
    if (cA !== 32'h0000_0001) begin errors++; $display("FAIL rise_count got=%h want=00000001", cA); end
    flag[0] = 1'b0;
    repeat (8) tick;
  endtask

  task automatic test_retrigger;
    int highA, highB, riseA, riseB;
    logic pA, pB;
    do_reset;
    highA = 0; highB = 0; riseA = 0; riseB = 0; pA = 0; pB = 0;
    for (int t = 0; t < 26; t++) begin
      flag[1] = (t == 0 || t == 4);
      tick;
      if (stA[1]) highA++;
      if (stB[1]) highB++;
      if (stA[1] && !pA) riseA++;
      if (stB[1] && !pB) riseB++;
      pA = stA[1];
      pB = stB[1];
    end
    checks++;
    if (highA !== 12 || riseA !== 1) begin errors++; $display("FAIL retrig_stretch got=%0d/%0d want=12/1", highA, riseA); end
    checks++;
    if (highB !== ST || riseB !== 1) begin errors++; $display("FAIL noretrig_stretch got=%0d/%0d want=%0d/1", highB, riseB, ST); end
    checks++;
    if (cA[15:8] !== 8'd2) begin errors++; $display("FAIL retrig_count got=%0d want=2", cA[15:8]); end
    checks++;
    if (cB[3:2] !== 2'd2) begin errors++; $display("FAIL noretrig_count got=%0d want=2", cB[3:2]); end
  endtask

  task automatic test_saturate;
    do_reset;
    for (int p = 0; p < 5; p++) begin
      flag[2] = 1'b1;
      tick;
      flag[2] = 1'b0;
      repeat (11) tick;
      checks++;
      if (cB[5:4] !== 2'((p + 1 > 3) ? 3 : p + 1)) begin
        errors++;
        $display("FAIL sat_count p=%0d got=%0d want=%0d", p, cB[5:4], (p + 1 > 3) ? 3 : p + 1);
      end
      checks++;
      if (cA[23:16] !== 8'(p + 1)) begin errors++; $display("FAIL wide_count p=%0d got=%0d want=%0d", p, cA[23:16], p + 1); end
    end
    flag[2] = 1'b1;
    tick;
    flag[2] = 1'b0;
    repeat (2) tick;
    clr[2] = 1'b1;
    tick;
    clr[2] = 1'b0;
    checks++;
    if (puA[2] !== 1'b1) begin errors++; $display("FAIL clear_event_pulse got=%b want=1", puA[2]); end
    checks++;
    if (cB[5:4] !== 2'd1 || cA[23:16] !== 8'd1) begin
      errors++;
      $display("FAIL clear_with_event got=%0d/%0d want=1/1", cB[5:4], cA[23:16]);
    end
    repeat (10) tick;
    clr[2] = 1'b1;
    tick;
    clr[2] = 1'b0;
    checks++;
    if (cB[5:4] !== 2'd0 || cA[23:16] !== 8'd0) begin
      errors++;
      $display("FAIL clear_only got=%0d/%0d want=0/0", cB[5:4], cA[23:16]);
    end
  endtask

  task automatic test_reset_mid;
    int r, pulses, pEdge, highs;
    do_reset;
    flag[0] = 1'b1;
    repeat (6) tick;
    checks++;
    if (stA[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_stretch got=%b want=1", stA[0]); end
    reset = 1'b1;
    tick;
    r = n;
    checks++;
    if ({lvA, puA, stA, lvB, puB, stB, cA, cB} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h want=0", {lvA, puA, stA, lvB, puB, stB, cA, cB});
    end
    reset = 1'b0;
    pulses = 0; pEdge = -1; highs = 0;
    for (int t = 0; t < 16; t++) begin
      tick;
      if (puA[0]) begin pulses++; pEdge = n; end
      if (stA[0]) highs++;
    end
    checks++;
    if (pulses !== 1 || pEdge !== r + 4) begin
      errors++;
      $display("FAIL held_pulse got=%0d@%0d want=1@%0d", pulses, pEdge, r + 4);
    end
    checks++;
    if (highs !== ST) begin errors++; $display("FAIL held_stretch got=%0d want=%0d", highs, ST); end
    checks++;
    if (cA[7:0] !== 8'd1) begin errors++; $display("FAIL held_count got=%0d want=1", cA[7:0]); end
    flag[0] = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_all_channels;
    int full, partial;
    do_reset;
    for (int rnd = 1; rnd <= 2; rnd++) begin
      full = 0;
      partial = 0;
      flag = '1;
      for (int t = 0; t < 10; t++) begin
        tick;
        if (puA === 4'b1111) full++;
        else if (puA !== 4'b0000) partial++;
      end
      flag = '0;
      repeat (10) tick;
      checks++;
      if (full !== 1 || partial !== 0) begin errors++; $display("FAIL all_pulse round=%0d got=%0d/%0d want=1/0", rnd, full, partial); end
      for (int c = 0; c < C; c++) begin
        checks++;
        if (cA[c*8 +: 8] !== 8'(rnd) || cB[c*2 +: 2] !== 2'(rnd)) begin
          errors++;
          $display("FAIL all_count ch=%0d got=%0d/%0d want=%0d", c, cA[c*8 +: 8], cB[c*2 +: 2], rnd);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [C*8-1:0] wantA;
    logic [C*2-1:0] wantB;
    do_reset;
    for (int t = 0; t < 2500; t++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 3) == 0) flag[c] = ~flag[c];
        clr[c] = ($urandom_range(0, 31) == 0);
      end
      tick;
      for (int c = 0; c < C; c++) begin
        wantA[c*8 +: 8] = 8'(cntA[c]);
        wantB[c*2 +: 2] = 2'(cntB[c]);
      end
      checks++;
      if ({lvA, puA, stA} !== {eLev, ePul, eStrA}) begin
        errors++;
        $display("FAIL rand_bitsA t=%0d got=%b want=%b", t, {lvA, puA, stA}, {eLev, ePul, eStrA});
      end
      checks++;
      if ({lvB, puB, stB} !== {eLev, ePul, eStrB}) begin
        errors++;
        $display("FAIL rand_bitsB t=%0d got=%b want=%b", t, {lvB, puB, stB}, {eLev, ePul, eStrB});
      end
      checks++;
      if (cA !== wantA || cB !== wantB) begin
        errors++;
        $display("FAIL rand_counts t=%0d got=%h/%h want=%h/%h", t, cA, cB, wantA, wantB);
      end
    end
    flag = '0;
    clr = '0;
  endtask

  initial begin
    test_reset;
    test_single_rise;
    test_retrigger;
    test_saturate;
    test_reset_mid;
    test_all_channels;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flag_sync_multi.md
Name: flag_sync_multi

Overview:
- Multi-channel successor to the single-flag crossing. It brings CHANNELS asynchronous flag/level inputs from foreign clock domains (video, GD-ROM, SPI, etc.) into the single `clock` domain.
- Per channel it provides:
  - a synchronised level;
  - a one-cycle rising-edge pulse;
  - a stretched pulse of programmable length, in retrigger or non-retrigger mode;
  - a saturating event counter.
- Sits at the boundary of the HDMI core's control logic and replaces the ad-hoc per-signal crossings.

Parameters:
- CHANNELS, 4, number of independent flag channels (≥1)
- SYNC_STAGES, 3, flops in each synchroniser chain (≥2)
- STRETCH, 8, cycles stretch_out stays high per accepted event (≥1)
- RETRIGGER, 1, 1 = a new event during stretch reloads the counter; 0 = events during stretch are ignored by the stretcher
- CNT_W, 8, width of each per-channel event counter (≥1)

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- flag_async  in  CHANNELS  asynchronous flag inputs, bit i = channel i
- count_clear  in  CHANNELS  synchronous clear of channel i event counter
- level_out  out  CHANNELS  synchronised level (last synchroniser stage)
- pulse_out  out  CHANNELS  registered one-cycle pulse per rising edge of level
- stretch_out  out  CHANNELS  stretched pulse
- event_count  out  CHANNELS*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset, applied while reset=1 at a clock edge, zeroes:
  - all synchroniser flops, prev registers, pulse_out, stretch_out, stretch counters and event counters;
  - consequently level_out=0.
- Reset asserted mid-stretch or mid-count aborts immediately. There is no residual output after reset deasserts.
- Synchroniser: sync[0] <= flag_async[i]; sync[k] <= sync[k-1]; level_out = sync[SYNC_STAGES-1].
  - Latency: a flag stable before edge E appears on level_out after edge E+SYNC_STAGES-1.
- Edge detect:
  - prev <= level_out each cycle;
  - pulse_out <= level_out & ~prev, so it is high for exactly one cycle, the cycle after level_out first goes high.
  - A level held high through reset release is treated as a rising edge: one pulse after the chain fills.
  - A falling edge produces nothing.
  - Minimum detectable input: high for ≥1 clock period (capture not guaranteed below that).
- Stretcher (per channel): counter rem of width clog2(STRETCH+1).
  - On an accepted event (the cycle pulse_out's next value is 1): rem <= STRETCH, stretch_out <= 1.
  - Otherwise, if rem>1: rem--.
  - If rem==1: rem<=0, stretch_out<=0.
  - stretch_out rises in the same cycle as pulse_out and stays high exactly STRETCH cycles for an isolated event.
  - RETRIGGER=1: an event while rem>0 reloads to STRETCH, so the high time extends to STRETCH cycles after the last event.
  - RETRIGGER=0: an event while rem>0 is ignored by the stretcher; pulse_out and the counter still fire.
  - STRETCH=1: stretch_out equals pulse_out.
- Event counter (per channel):
  - count_clear and event in the same cycle -> count = 1;
  - clear only -> 0;
  - event only -> count+1, saturating at 2^CNT_W-1 (no wrap);
  - clear has priority over saturation.
- Channels are fully independent; simultaneous events on all channels must be handled in the same cycle.

Decomposition:
- Shared package flag_sync_pkg: function clog2, localparam REM_W derived from STRETCH, reset-value constants.
- One sub-module is natural: flag_sync_chan (one channel: synchroniser, edge detect, stretcher, counter).
  - Instantiated CHANNELS times via generate in flag_sync_multi.
  - The top contains only packing/unpacking.

Test Plan:
- Reset release, all inputs 0 for 20 cycles -> all outputs 0, event_count=0.
- Ch0 rises at edge 10 (SYNC_STAGES=3, STRETCH=8) and holds -> level_out[0] at cycle 12, pulse_out[0] one cycle at 13, stretch_out[0] high cycles 13–20, count0=1; other channels untouched.
- RETRIGGER=1, ch1 gets a 1-cycle high, then another 4 cycles after the first pulse -> stretch_out[1] high 12 consecutive cycles, count1=2. Repeat with RETRIGGER=0 -> stretch high 8 cycles, count1=2.
- CNT_W=2, ch2 gets 5 separated pulses -> count2 goes 1,2,3,3,3. Assert count_clear[2] in the same cycle as a 6th pulse -> count2=1.
- Flag held high across reset, reset asserted during an active stretch -> outputs 0 the cycle after the reset edge. After deassert: one pulse 4 cycles later, full 8-cycle stretch.
- All 4 channels pulse in the same cycle -> pulse_out=4'b1111 for one cycle; every counter increments by 1.
